nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Time-multiplexed controller for the 4-input, 8-hidden, 1-output network. One shared multiply-accumulate unit evaluates all hidden and output neurons in sequence, in place of the eight parallel hidden-neuron instances. The block streams weights from an external synchronous weight memory and keeps the eight hidden activations in an internal register file. It reports the final output with a start/busy/done handshake.

## Interface
Parameters:
- N_IN, 4: inputs per hidden neuron
- N_HID, 8: hidden neurons
- X_W, 4: input and weight width, unsigned
- H_W, 10: hidden activation width
- ACC_W, 23: result width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request a run; accepted only in IDLE or DONE
- abort_i  in  1  synchronous abort; overrides start_i
- x_i  in  N_IN*X_W  input vector, x0 in the LSBs; sampled on start acceptance
- w_addr_o  out  6  weight memory address
- w_rd_o  out  1  weight read strobe
- w_data_i  in  X_W  weight data, valid one cycle after w_rd_o
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse; result_o is valid
- result_o  out  ACC_W  output neuron value; held until the next start is accepted
- curr_state_o  out  3  state encoding, for debug pins

## Operation
- Weight map:
  - address 4*j+i = weight of hidden neuron j, input i (0..31)
  - address 32+j = output weight for hidden neuron j (32..39)
- States: IDLE (0), HID (1), OUT (2), DRAIN (3), DONE (4).
- IDLE or DONE with start_i=1 and abort_i=0:
  - latch x_i
  - clear the address counter k
  - go to HID
- HID:
  - issue w_addr_o=k with w_rd_o=1, k=0..31
  - at k=31, go to OUT
- OUT:
  - issue k=32..39
  - at k=39, go to DRAIN
- DRAIN:
  - accumulate the last product
  - register result_o
  - go to DONE
- DONE: pulse done_o for one cycle. Next state is HID if a start is accepted, otherwise IDLE.
- Datapath, one cycle behind the address stream:
  - Hidden product = w_data_i * x[k mod 4]. The accumulator clears on the first product of each neuron.
  - After the 4th product, the accumulator value is written to hidden[j], H_W bits. The maximum is 4*15*15=900, so there is no overflow.
  - Output product = w_data_i * hidden[k-32]. The result is the zero-extended sum; the maximum is 8*900*15=108000.
- Hidden activation is identity; all arithmetic is unsigned.
- abort_i=1 in any state: next state is IDLE, w_rd_o=0 from the next cycle, no done_o, result_o unchanged.
- start_i during HID, OUT or DRAIN is ignored. It is not queued.
- A read is issued only when w_rd_o=1. w_addr_o is held at its last value otherwise.

## Timing
- Reset values: state IDLE, w_addr_o=0, w_rd_o=0, busy_o=0, done_o=0, result_o=0, curr_state_o=0, hidden[*]=0.
- Start accepted at edge T:
  - addresses 0..39 appear at T+1..T+40, one per cycle, no bubbles
  - products accumulate at T+2..T+41
  - hidden[7] is written at T+33 and first read at T+41
  - done_o=1 at T+42, with result_o valid in the same cycle
- busy_o=1 exactly for T+1..T+41.
- Back-to-back: a start accepted in DONE (T+42) gives a first address at T+43. The run period is 42 cycles.
- Reset asserted mid-run: everything returns to reset values immediately. The weight memory may see a truncated stream, which is harmless.

## Structure
- Package nn_seq_pkg holds:
  - the state enum with the encodings above
  - N_IN, N_HID, X_W, H_W, ACC_W
  - address constants HID_BASE=0, OUT_BASE=32, LAST_ADDR=39
- Sub-module mac_unit holds one multiplier and one ACC_W accumulator, with inputs clr_i (load product), en_i and a, b. It is instantiated once.
- The FSM, address counter, input latch and hidden register file live in the top module.

## Test plan
- All weights 1, x=(1,2,3,4) → every hidden value 10, result_o=80, done_o at T+42, busy_o high for 41 cycles.
- All weights 15, x=(15,15,15,15) → hidden values 900, result_o=108000, no truncation.
- Hidden weights = (address mod 4)+1, output weights = j+1, x=(1,0,0,0) → hidden[j]=1, result_o=36.
- abort_i at T+10 → state IDLE at T+11, w_rd_o=0, no done_o, result_o keeps its previous value. A new start then completes normally.
- start_i pulsed at T+5 with a different x → ignored, original result. start_i held high → new runs begin at T+42, T+84, with done_o pulsing every 42 cycles.
- rst_i asserted at T+20 for 1 cycle → all outputs return to reset values asynchronously. The next run produces a correct result.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the time-multiplexed 4-8-1 network sequencer.
package nn_seq_pkg;
    localparam int unsigned N_IN   = 4;
    localparam int unsigned N_HID  = 8;
    localparam int unsigned X_W    = 4;
    localparam int unsigned H_W    = 10;
    localparam int unsigned ACC_W  = 23;
    localparam int unsigned ADDR_W = 6;

    localparam logic [ADDR_W-1:0] HID_BASE  = 6'd0;
    localparam logic [ADDR_W-1:0] OUT_BASE  = 6'd32;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 6'd39;
    localparam logic [ADDR_W-1:0] HID_LAST  = 6'd31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HID   = 3'd1,
        ST_OUT   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/mac_unit.sv
// Single shared multiply-accumulate; sum_c_o exposes the value the accumulator is about to take.
module mac_unit
    import nn_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [X_W-1:0]   a_i,
    input  logic [H_W-1:0]   b_i,
    output logic [ACC_W-1:0] sum_c_o
);
    localparam int unsigned PROD_W = X_W + H_W;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_q;

    always_comb begin
        prod    = PROD_W'(a_i) * PROD_W'(b_i);
        sum_c_o = clr_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_c_o;
        end
    end
endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequences hidden and output neurons through one MAC, streaming weights from a synchronous memory.
module nn_layer_sequencer
    import nn_seq_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [N_IN*X_W-1:0]   x_i,
    output logic [ADDR_W-1:0]     w_addr_o,
    output logic                  w_rd_o,
    input  logic [X_W-1:0]        w_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ACC_W-1:0]      result_o,
    output logic [2:0]            curr_state_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ACC_W-1:0]  result_q, result_d;

    // Address/valid of the read whose data is on w_data_i this cycle
    logic [ADDR_W-1:0] paddr_q;
    logic              pvld_q;

    logic [X_W-1:0]    x_q   [N_IN];
    logic [H_W-1:0]    hid_q [N_HID];

    logic              accept_c;
    logic              mac_clr_c;
    logic [H_W-1:0]    mac_b_c;
    logic [ACC_W-1:0]  sum_c;

    assign accept_c = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i && !abort_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Outputs are computed for the state being entered so they line up with it
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    state_d = ST_HID;
                    addr_d  = HID_BASE;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_HID: begin
                rd_d   = 1'b1;
                busy_d = 1'b1;
                if (addr_q == HID_LAST) begin
                    state_d = ST_OUT;
                    addr_d  = OUT_BASE;
                end else begin
                    addr_d = addr_q + 6'd1;
                end
            end
            ST_OUT: begin
                busy_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_d   = 1'b1;
                    addr_d = addr_q + 6'd1;
                end
            end
            ST_DRAIN: begin
                state_d  = ST_DONE;
                done_d   = 1'b1;
                result_d = sum_c;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d  = ST_IDLE;
            rd_d     = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // Datapath: read pipeline tracking, input latch, hidden register file
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            paddr_q <= '0;
            pvld_q  <= 1'b0;
            for (int unsigned i = 0; i < N_IN; i++) x_q[i] <= '0;
            for (int unsigned j = 0; j < N_HID; j++) hid_q[j] <= '0;
        end else begin
            paddr_q <= addr_q;
            pvld_q  <= rd_q;
            if (accept_c) begin
                for (int unsigned i = 0; i < N_IN; i++) x_q[i] <= x_i[i*X_W +: X_W];
            end
            if (pvld_q && !paddr_q[5] && (paddr_q[1:0] == 2'd3)) begin
                hid_q[paddr_q[4:2]] <= sum_c[H_W-1:0];
            end
        end
    end

    always_comb begin
        mac_b_c   = H_W'(x_q[paddr_q[1:0]]);
        mac_clr_c = (paddr_q[1:0] == 2'd0);
        if (paddr_q[5]) begin
            mac_b_c   = hid_q[paddr_q[2:0]];
            mac_clr_c = (paddr_q[2:0] == 3'd0);
        end
    end

    mac_unit u_mac (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (mac_clr_c),
        .en_i    (pvld_q),
        .a_i     (w_data_i),
        .b_i     (mac_b_c),
        .sum_c_o (sum_c)
    );

    assign w_addr_o     = addr_q;
    assign w_rd_o       = rd_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign curr_state_o = state_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized and directed checks of the layer sequencer against a plain arithmetic network model.
module tb_nn_layer_sequencer;
    import nn_seq_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic                 abort_i;
    logic [N_IN*X_W-1:0]  x_i;
    logic [5:0]           w_addr_o;
    logic                 w_rd_o;
    logic [X_W-1:0]       w_data_i;
    logic                 busy_o;
    logic                 done_o;
    logic [ACC_W-1:0]     result_o;
    logic [2:0]           curr_state_o;

    int unsigned mem [64];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk_i = ~clk_i;

    // Synchronous weight memory
    always @(posedge clk_i) if (w_rd_o) w_data_i <= X_W'(mem[w_addr_o]);

    nn_layer_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .x_i          (x_i),
        .w_addr_o     (w_addr_o),
        .w_rd_o       (w_rd_o),
        .w_data_i     (w_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .curr_state_o (curr_state_o)
    );

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned model(input logic [15:0] xv);
        longint unsigned h, r;
        r = 0;
        for (int j = 0; j < 8; j++) begin
            h = 0;
            for (int i = 0; i < 4; i++) h += mem[4*j+i] * xv[4*i +: 4];
            r += mem[32+j] * h;
        end
        return r;
    endfunction

    task automatic fill_rand();
        for (int a = 0; a < 64; a++) mem[a] = (a < 40) ? $urandom_range(0, 15) : 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"},  w_addr_o, 0);
        chk({tag, "_rd"},    w_rd_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_res"},   result_o, 0);
        chk({tag, "_state"}, curr_state_o, 0);
    endtask

    // One run from IDLE; optional ignored start pulse at cycle pulse_at
    task automatic run_check(input string tag, input logic [15:0] xv,
                             input longint unsigned exp, input int pulse_at);
        int busy_n, done_at, done_n, addr_bad;
        busy_n = 0; done_at = 0; done_n = 0; addr_bad = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        x_i     = xv;
        @(posedge clk_i);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                start_i = 1'b0;
                x_i     = 16'($urandom);
            end
            if (busy_o) busy_n++;
            if (c <= 40 && (!w_rd_o || w_addr_o != 6'(c - 1))) addr_bad++;
            if (done_o) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = c;
                    chk({tag, "_result"}, result_o, exp);
                end
            end
            if (pulse_at != 0 && c == pulse_at) begin
                start_i = 1'b1;
                x_i     = ~xv;
            end
            if (pulse_at != 0 && c == pulse_at + 1) start_i = 1'b0;
        end
        chk({tag, "_done_cycle"}, done_at, 42);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_busy_cycles"}, busy_n, 41);
        chk({tag, "_addr_stream_bad"}, addr_bad, 0);
        chk({tag, "_held"}, result_o, exp);
        chk({tag, "_idle"}, curr_state_o, 0);
    endtask

    initial begin
        longint unsigned prev, exp;
        logic [15:0] xv;
        int seen;
        int done_pos [$];

        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; x_i = '0;
        for (int a = 0; a < 64; a++) mem[a] = 0;
        repeat (3) @(negedge clk_i);
        check_reset_vals("rst_held");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_vals("rst_release");

        for (int a = 0; a < 40; a++) mem[a] = 1;
        run_check("ones", 16'h4321, 80, 0);

        for (int a = 0; a < 40; a++) mem[a] = 15;
        run_check("max", 16'hFFFF, 108000, 0);

        for (int a = 0; a < 32; a++) mem[a] = (a % 4) + 1;
        for (int j = 0; j < 8; j++) mem[32+j] = j + 1;
        run_check("pattern", 16'h0001, 36, 0);

        for (int r = 0; r < 5; r++) begin
            fill_rand();
            xv = 16'($urandom);
            run_check($sformatf("rand%0d", r), xv, model(xv), 0);
        end

        fill_rand();
        xv = 16'($urandom);
        run_check("ignored_start", xv, model(xv), 5);
        prev = model(xv);

        // Abort sampled at T+10
        fill_rand();
        xv = 16'($urandom);
        @(negedge clk_i);
        start_i = 1'b1; x_i = xv;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 2; c <= 10; c++) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_state", curr_state_o, 0);
        chk("abort_rd", w_rd_o, 0);
        chk("abort_busy", busy_o, 0);
        seen = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_result_kept", result_o, prev);
        run_check("after_abort", xv, model(xv), 0);

        // start held high: back-to-back runs every 42 cycles
        fill_rand();
        xv = 16'($urandom);
        exp = model(xv);
        @(negedge clk_i);
        start_i = 1'b1; x_i = xv;
        @(posedge clk_i);
        for (int c = 1; c <= 126; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_pos.push_back(c);
                chk($sformatf("b2b_result_%0d", c), result_o, exp);
            end
        end
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("b2b_done_count", done_pos.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_done_at_%0d", i), (i < done_pos.size()) ? done_pos[i] : 0, 42 * (i + 1));
        chk("b2b_idle", curr_state_o, 0);

        // Asynchronous reset mid-run
        fill_rand();
        xv = 16'($urandom);
        @(negedge clk_i);
        start_i = 1'b1; x_i = xv;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 2; c <= 20; c++) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_reset_vals("rst_async");
        @(negedge clk_i);
        rst_i = 1'b0;
        run_check("after_reset", xv, model(xv), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
